cam_framewriter: RTL

CAM_FRAMEWRITER -- requirements
Module: cam_framewriter

---
 rtl/cam_framewriter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cam_framewriter.sv
// Camera frame writer: captures one full frame per request into a small FIFO
// and streams {pixel index, pixel} words to a ready/valid sink.
module cam_framewriter #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 258,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] vid_pixel,
    input  logic        vid_pixsync,
    input  logic        vid_vsync,
    input  logic        vid_visible,
    input  logic        vid_locked,
    input  logic        capture_req,
    output logic [16:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        aborted,
    output logic [7:0]  frame_count
);

    localparam int          PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [16:0] LAST = 17'(H_PIXELS * V_LINES - 1);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_SOF = 3'd2;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]    state;
    logic [16:0]   idx;
    logic [28:0]   mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wptr, rptr, rptr_nxt;
    logic [PW:0]   count, count_nxt;
    logic [11:0]   head_pix;
    logic [28:0]   push_word, head_nxt;
    logic          lock_lost, take, pop, push, full;

    assign lock_lost = !vid_locked &&
                       (state == S_ARM || state == S_WAIT_SOF || state == S_CAPTURE);
    assign take      = state == S_CAPTURE && vid_locked && vid_pixsync && vid_visible;
    assign pop       = wr_valid && wr_ready;
    assign full      = count == FULL;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = take && (!full || pop);
    assign push_word = {idx, vid_pixel};
    assign rptr_nxt  = rptr + PW'(pop);
    assign count_nxt = count + (PW + 1)'(push) - (PW + 1)'(pop);

    // Next head of queue: the word being pushed if the FIFO drains to empty
    // this cycle, otherwise the stored entry at the advanced read pointer.
    always_comb begin
        head_nxt = mem[rptr_nxt];
        if (count == '0 || (count == (PW + 1)'(1) && pop))
            head_nxt = push_word;
    end

    assign busy    = state != S_IDLE;
    assign wr_data = {4'b0, head_pix};

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            head_pix <= '0;
        end else if (lock_lost) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wr_valid <= 1'b0;
        end else begin
            wptr     <= wptr + PW'(push);
            rptr     <= rptr_nxt;
            count    <= count_nxt;
            wr_valid <= count_nxt != '0;
            if (count_nxt != '0)
                {wr_addr, head_pix} <= head_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            aborted     <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            if (lock_lost) begin
                state   <= S_IDLE;
                aborted <= 1'b1;
                done    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (capture_req) begin
                        state    <= S_ARM;
                        overflow <= 1'b0;
                        aborted  <= 1'b0;
                        idx      <= '0;
                    end
                    S_ARM:      if (vid_vsync)  state <= S_WAIT_SOF;
                    S_WAIT_SOF: if (!vid_vsync) state <= S_CAPTURE;
                    S_CAPTURE: if (take) begin
                        // Dropped pixels still consume an index so later addresses stay true.
                        idx <= idx + 17'd1;
                        if (!push)
                            overflow <= 1'b1;
                        if (idx == LAST)
                            state <= S_DRAIN;
                    end
                    S_DRAIN: if (count == '0) begin
                        state       <= S_IDLE;
                        done        <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
